// File: rtl/bcd2bin32.sv
// bcd2bin32: iterative packed-BCD to 32-bit unsigned binary converter.
// One decimal digit per clock, most significant first: acc = acc*10 + digit.
// Shares the start/busy/fin handshake and digit layout of bin2bcd32.
// Optional macro BCD2BIN32_DIGIT_CHECK_EN: flag used digits greater than 9 on err.
module bcd2bin32 #(
   parameter int NDIG = 10
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        en,
   input  logic [3:0]  bcd0,
   input  logic [3:0]  bcd1,
   input  logic [3:0]  bcd2,
   input  logic [3:0]  bcd3,
   input  logic [3:0]  bcd4,
   input  logic [3:0]  bcd5,
   input  logic [3:0]  bcd6,
   input  logic [3:0]  bcd7,
   input  logic [3:0]  bcd8,
   input  logic [3:0]  bcd9,
   output logic [31:0] bin,
   output logic        ovf,
   output logic        err,
   output logic        busy,
   output logic        fin
);

   localparam int SW = 4 * NDIG;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [33:0]    acc_q, acc_d, acc_step;
   logic [SW-1:0]  sr_q, sr_d, din;
   logic [3:0]     cnt_q, cnt_d;
   logic [3:0]     top;
   logic [31:0]    bin_q, bin_d;
   logic           ovf_q, ovf_d;
   logic [3:0]     dig [10];

   assign dig = '{bcd0, bcd1, bcd2, bcd3, bcd4, bcd5, bcd6, bcd7, bcd8, bcd9};

   // Pack the used digits, units in the low nibble; unused digit ports are dropped
   always_comb begin
      din = '0;
      for (int i = 0; i < NDIG; i++) din[4*i +: 4] = dig[i];
   end

   // MSD sits at the top of the shift register; acc*10 as (acc<<3)+(acc<<1).
   // 34 bits hold ten digits of 15, so the sum never wraps.
   assign top      = sr_q[SW-1 -: 4];
   assign acc_step = {acc_q[30:0], 3'b000} + {acc_q[32:0], 1'b0} + {30'd0, top};

   // Next-state and datapath updates for the IDLE/RUN/DONE sequence
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (en) begin
               sr_d    = din;
               acc_d   = '0;
               cnt_d   = 4'(NDIG);
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_step;
            sr_d  = sr_q << 4;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = DONE;
               bin_d   = acc_step[31:0];
               ovf_d   = |acc_step[33:32];
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         acc_q   <= '0;
         sr_q    <= '0;
         cnt_q   <= '0;
         bin_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef BCD2BIN32_DIGIT_CHECK_EN
   logic derr_q, derr_d;
   logic err_q, err_d;

   // Sticky invalid-digit flag over the consumed digits, published on DONE entry
   always_comb begin
      derr_d = derr_q;
      err_d  = err_q;
      case (state_q)
         IDLE: if (en) derr_d = 1'b0;
         RUN: begin
            derr_d = derr_q | (top > 4'd9);
            if (cnt_q == 4'd1) err_d = derr_d;
         end
         default: ;
      endcase
   end

   // Digit-check registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         derr_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         derr_q <= derr_d;
         err_q  <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign bin  = bin_q;
   assign ovf  = ovf_q;
   assign busy = (state_q != IDLE);
   assign fin  = (state_q == DONE);

endmodule

// File: tb/tb_bcd2bin32.sv
// Scoreboard bench for bcd2bin32: driver pushes expected results, monitor pops on fin.
module tb_bcd2bin32;

   localparam int NDIG = 10;
`ifdef BCD2BIN32_DIGIT_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        en  = 1'b0;
   logic [39:0] dg  = '0;
   logic [31:0] bin;
   logic        ovf, err, busy, fin;

   typedef struct {
      logic [31:0] b;
      logic        o;
      logic        e;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] last_bin = '0;

   always #5 CLK = ~CLK;

   bcd2bin32 #(.NDIG(NDIG)) dut (
      .CLK(CLK), .RST(RST), .en(en),
      .bcd0(dg[3:0]),   .bcd1(dg[7:4]),   .bcd2(dg[11:8]),  .bcd3(dg[15:12]),
      .bcd4(dg[19:16]), .bcd5(dg[23:20]), .bcd6(dg[27:24]), .bcd7(dg[31:28]),
      .bcd8(dg[35:32]), .bcd9(dg[39:36]),
      .bin(bin), .ovf(ovf), .err(err), .busy(busy), .fin(fin)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Monitor: every fin must match the oldest outstanding expectation
   always @(negedge CLK) begin
      if (!RST && fin) begin
         if (sb.size() == 0) begin
            chk("unexpected_fin", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("bin", {32'd0, bin}, {32'd0, e.b});
            chk("ovf", {63'd0, ovf}, {63'd0, e.o});
            chk("err", {63'd0, err}, {63'd0, e.e});
         end
      end
   end

   // One conversion; poke=1 also requests a start mid-run, which must be ignored
   task automatic run(input logic [39:0] d, input logic [31:0] eb, input logic eo,
                      input logic ee, input bit poke);
      exp_t e;
      int   k;
      bit   got;
      @(negedge CLK);
      dg = d;
      en = 1'b1;
      e.b = eb; e.o = eo; e.e = ee;
      sb.push_back(e);
      @(posedge CLK); #1;
      en  = 1'b0;
      dg  = 40'h5A5A5A5A5A;
      got = 1'b0;
      for (k = 1; k <= 20; k++) begin
         if (poke && k == 3) en = 1'b1;
         if (poke && k == 4) en = 1'b0;
         @(posedge CLK); #1;
         if (poke && k == 5) chk("bin_hold", {32'd0, bin}, {32'd0, last_bin});
         if (fin) begin
            got = 1'b1;
            break;
         end
      end
      chk("fin_latency", {32'd0, 31'd0, got, 32'(k)}, {32'd0, 31'd0, 1'b1, 32'(NDIG)});
      chk("busy_at_fin", {63'd0, busy}, 64'd1);
      last_bin = eb;
      @(posedge CLK); #1;
      chk("idle_after_fin", {62'd0, busy, fin}, 64'd0);
   endtask

   initial begin
      logic [39:0] d;
      logic [31:0] v, t;

      repeat (2) @(posedge CLK);
      #1;
      chk("reset_out", {29'd0, bin, ovf, err, busy, fin}, 64'd0);
      @(negedge CLK);
      RST = 1'b0;

      run(40'h1234567890, 32'h499602D2, 1'b0, 1'b0, 1'b0);
      run(40'h4294967295, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
      run(40'h4294967296, 32'h00000000, 1'b1, 1'b0, 1'b0);
      run(40'h9999999999, 32'h540BE3FF, 1'b1, 1'b0, 1'b0);
      run(40'h0000000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
      run(40'h000000A000, 32'd10000,    1'b0, CHK,  1'b0);

      // Abort mid-conversion: outputs clear, and no fin may follow
      @(negedge CLK);
      dg = 40'h1111111111;
      en = 1'b1;
      @(posedge CLK); #1;
      en = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK); #1;
      chk("abort_out", {29'd0, bin, ovf, err, busy, fin}, 64'd0);
      @(negedge CLK);
      RST = 1'b0;
      repeat (15) @(posedge CLK);
      last_bin = '0;

      run(40'h0000000042, 32'd42, 1'b0, 1'b0, 1'b0);

      // Round trip: bench-side binary to BCD, then the DUT back to binary
      for (int n = 0; n < 40; n++) begin
         v = $urandom;
         t = v;
         d = '0;
         for (int i = 0; i < 10; i++) begin
            d[4*i +: 4] = 4'(t % 10);
            t = t / 10;
         end
         run(d, v, 1'b0, 1'b0, 1'b0);
      end

      repeat (5) @(posedge CLK);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
